qpu_exu_longp_wbck_arb: RTL
===========================

# qpu_exu_longp_wbck_arb

Parametrised long-pipe write-back arbiter for the QPU execution unit. It collects completions from NCH long-pipe units (LSU, measurement, multi-cycle classical units), and retires them strictly in OITF order by matching each unit's instruction tag against the OITF head pointer. The winning result goes through one registered output slot into the final write-back module. It replaces the single-source, combinational long-pipe write-back path.

## Interface
- NCH, 2: number of long-pipe channels (1..8); channel 0 has the highest priority on a tag collision.
- XLEN, 32: result data width.
- RFIDX_W, 5: register-file index width.
- ITAG_W, 2: OITF pointer width (OITF depth = 2^ITAG_W).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ch_wbck_i_valid  in  NCH  per-channel completion valid.
- ch_wbck_i_ready  out  NCH  per-channel accept; at most one bit set per cycle.
- ch_wbck_i_data  in  NCH*XLEN  per-channel result; channel k occupies bits [k*XLEN +: XLEN].
- ch_wbck_i_itag  in  NCH*ITAG_W  per-channel OITF tag; channel k occupies bits [k*ITAG_W +: ITAG_W].
- oitf_empty  in  1  OITF holds no entries.
- oitf_ret_ptr  in  ITAG_W  tag of the OITF head entry.
- oitf_ret_rdidx  in  RFIDX_W  destination index of the head entry.
- oitf_ret_rdwen  in  1  head entry writes the register file.
- oitf_ret_ena  out  1  retire the head entry this cycle.
- longp_wbck_o_valid  out  1  output slot valid.
- longp_wbck_o_ready  in  1  final write-back accepts.
- longp_wbck_o_data  out  XLEN  registered result.
- longp_wbck_o_rdidx  out  RFIDX_W  registered destination index.
- longp_proto_err  out  1  sticky protocol-error flag.

## Operation
- Match: match[k] = ch_wbck_i_valid[k] & (itag_k == oitf_ret_ptr) & ~oitf_empty.
- Select: the lowest-index set bit of match is sel. Any channel without a match waits, with ready = 0.
- Output slot free: slot_free = ~longp_wbck_o_valid | longp_wbck_o_ready.
- Accept: acc = |match & (~oitf_ret_rdwen | slot_free).
  - ch_wbck_i_ready[sel] = acc.
  - All other ready bits are 0.
  - oitf_ret_ena = acc.
- On acc with oitf_ret_rdwen = 1: the slot loads data[sel] and oitf_ret_rdidx, and valid is set.
- On acc with oitf_ret_rdwen = 0: the entry retires without using the slot, and the slot is unchanged.
- Slot update when there is no load:
  - If valid & ready, valid clears.
  - Otherwise the slot holds.
  - Load and drain in the same cycle is allowed, giving full throughput.
- longp_proto_err sets on either condition below, and clears only on rst:
  - popcount(match) > 1.
  - oitf_empty & |ch_wbck_i_valid.
- Data and rdidx are held stable while valid & ~ready.

## Timing
- Reset values:
  - longp_wbck_o_valid = 0.
  - longp_wbck_o_data = 0.
  - longp_wbck_o_rdidx = 0.
  - longp_proto_err = 0.
- The combinational outputs ch_wbck_i_ready and oitf_ret_ena follow their inputs. While rst is high, they are forced to 0.
- Latency: a completion accepted in cycle N is presented on longp_wbck_o_* in cycle N+1.
- Sustained rate: one retire per cycle when longp_wbck_o_ready stays high.
- Backpressure: if the slot is full and ready = 0, a matching rdwen = 1 completion stalls with ready = 0. A matching rdwen = 0 completion still retires.
- The out-of-order arrival of tag T+1 before tag T stalls T+1 until T retires and the pointer advances.
- ITAG_W pointer wrap is handled by equality compare only. No ordering arithmetic is performed.
- rst mid-operation: a buffered result is discarded (valid = 0 in the next cycle). No retire is issued while rst is high.
- Combinational paths: input valid/itag to ready/ret_ena, and longp_wbck_o_ready to channel ready. There is no path from input data to any output.

## Test plan
- Test 1, NCH = 3:
  - Stimulus: ptr = 1, rdwen = 1, rdidx = 5. ch2 is valid with itag = 1 and data = 0xA5A5_0001. ch0 is valid with itag = 2.
  - Required response: ready = 3'b100 and ret_ena = 1. The next cycle shows o_valid = 1, data = 0xA5A5_0001, rdidx = 5.
- Test 2:
  - Stimulus: the slot is full, o_ready = 0, and a matching rdwen = 1 completion arrives.
  - Required response: ready = 0 and ret_ena = 0 for 3 cycles. Raising o_ready produces acceptance in that same cycle, and the new data appears the next cycle.
- Test 3:
  - Stimulus: the slot is full with o_ready = 0, and a matching rdwen = 0 completion arrives.
  - Required response: ret_ena = 1 and the slot contents are unchanged.
- Test 4:
  - Stimulus: 8 back-to-back completions with tags 0,1,2,3,0,1,2,3 across 2 channels, with o_ready held at 1.
  - Required response: 8 outputs in tag order on 8 consecutive cycles.
- Test 5:
  - Stimulus: ch0 and ch1 are both valid with tag = ptr.
  - Required response: ch0 is accepted and longp_proto_err = 1 from the next cycle until rst.
- Test 6:
  - Stimulus: rst is asserted while o_valid = 1.
  - Required response: the next cycle has o_valid = 0, data = 0, err = 0, and ready and ret_ena are 0 for the whole reset.

Source files
------------

// File: rtl/qpu_exu_longp_wbck_arb_if.sv
// Port bundle for the long-pipe write-back arbiter: channel completions, the
// OITF head view, and the registered output slot toward final write-back.
interface qpu_exu_longp_wbck_arb_if #(
    parameter int NCH     = 2,
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5,
    parameter int ITAG_W  = 2
);
    logic [NCH-1:0]        ch_wbck_i_valid;
    logic [NCH-1:0]        ch_wbck_i_ready;
    logic [NCH*XLEN-1:0]   ch_wbck_i_data;
    logic [NCH*ITAG_W-1:0] ch_wbck_i_itag;
    logic                  oitf_empty;
    logic [ITAG_W-1:0]     oitf_ret_ptr;
    logic [RFIDX_W-1:0]    oitf_ret_rdidx;
    logic                  oitf_ret_rdwen;
    logic                  oitf_ret_ena;
    logic                  longp_wbck_o_valid;
    logic                  longp_wbck_o_ready;
    logic [XLEN-1:0]       longp_wbck_o_data;
    logic [RFIDX_W-1:0]    longp_wbck_o_rdidx;
    logic                  longp_proto_err;

    modport master (
        output ch_wbck_i_valid, ch_wbck_i_data, ch_wbck_i_itag,
        output oitf_empty, oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_rdwen,
        output longp_wbck_o_ready,
        input  ch_wbck_i_ready, oitf_ret_ena,
        input  longp_wbck_o_valid, longp_wbck_o_data, longp_wbck_o_rdidx,
        input  longp_proto_err
    );

    modport slave (
        input  ch_wbck_i_valid, ch_wbck_i_data, ch_wbck_i_itag,
        input  oitf_empty, oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_rdwen,
        input  longp_wbck_o_ready,
        output ch_wbck_i_ready, oitf_ret_ena,
        output longp_wbck_o_valid, longp_wbck_o_data, longp_wbck_o_rdidx,
        output longp_proto_err
    );
endinterface

// File: rtl/qpu_exu_longp_wbck_arb.sv
// Long-pipe write-back arbiter: retires channel completions strictly in OITF
// order by tag match and buffers register writes in one output slot.
module qpu_exu_longp_wbck_arb #(
    parameter int NCH     = 2,
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5,
    parameter int ITAG_W  = 2
) (
    input logic clk,
    input logic rst,
    qpu_exu_longp_wbck_arb_if.slave bus
);

    logic [NCH-1:0]     grant_p0;
    logic [XLEN-1:0]    sel_data_p0;
    logic               any_match_p0;
    logic               multi_match_p0;
    logic               slot_free_p0;
    logic               acc_p0;
    logic               load_p0;
    logic               empty_err_p0;

    logic               slot_vld_p1;
    logic [XLEN-1:0]    slot_data_p1;
    logic [RFIDX_W-1:0] slot_rdidx_p1;
    logic               err_p1;

    // Stage p0: tag match against OITF head, lowest-index channel wins
    always_comb begin
        logic m;
        grant_p0       = '0;
        sel_data_p0    = '0;
        any_match_p0   = 1'b0;
        multi_match_p0 = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            m = bus.ch_wbck_i_valid[k] & ~bus.oitf_empty &
                (bus.ch_wbck_i_itag[k*ITAG_W +: ITAG_W] == bus.oitf_ret_ptr);
            if (m) begin
                if (any_match_p0) begin
                    multi_match_p0 = 1'b1;
                end else begin
                    grant_p0[k] = 1'b1;
                    sel_data_p0 = bus.ch_wbck_i_data[k*XLEN +: XLEN];
                end
                any_match_p0 = 1'b1;
            end
        end
    end

    assign slot_free_p0 = ~slot_vld_p1 | bus.longp_wbck_o_ready;
    // Entries without a register write never need the slot, so they retire under backpressure.
    assign acc_p0       = ~rst & any_match_p0 & (~bus.oitf_ret_rdwen | slot_free_p0);
    assign load_p0      = acc_p0 & bus.oitf_ret_rdwen;
    assign empty_err_p0 = bus.oitf_empty & (|bus.ch_wbck_i_valid);

    assign bus.ch_wbck_i_ready = grant_p0 & {NCH{acc_p0}};
    assign bus.oitf_ret_ena    = acc_p0;

    // Stage p1: registered output slot and sticky protocol error
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld_p1   <= 1'b0;
            slot_data_p1  <= '0;
            slot_rdidx_p1 <= '0;
            err_p1        <= 1'b0;
        end else begin
            if (load_p0) begin
                slot_vld_p1   <= 1'b1;
                slot_data_p1  <= sel_data_p0;
                slot_rdidx_p1 <= bus.oitf_ret_rdidx;
            end else if (slot_vld_p1 & bus.longp_wbck_o_ready) begin
                slot_vld_p1   <= 1'b0;
            end
            if (multi_match_p0 | empty_err_p0) begin
                err_p1 <= 1'b1;
            end
        end
    end

    assign bus.longp_wbck_o_valid = slot_vld_p1;
    assign bus.longp_wbck_o_data  = slot_data_p1;
    assign bus.longp_wbck_o_rdidx = slot_rdidx_p1;
    assign bus.longp_proto_err    = err_p1;

endmodule
